// File: rtl/qspi_flash_responder.sv
// QSPI flash target: answers Quad I/O Fast Read (0xEB) with continuous-read (XIP)
// mode, serving bytes from an internal byte memory that a side port preloads.
module qspi_flash_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sck,
    input  logic          ce_n,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic          io_oe,
    output logic          xip,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [7:0]    mem_wdata
);

    localparam logic [3:0] CMD_LAST   = 4'd7;
    localparam logic [3:0] ADDR_LAST  = 4'd5;
    localparam logic [3:0] MODE_LAST  = 4'd1;
    localparam logic [3:0] DUMMY_LAST = 4'd3;
    localparam logic [7:0] CMD_QIOR   = 8'hEB;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE
    } state_t;

    state_t         state, state_n, cur;
    logic           sck_d;
    logic           rise, fall;
    logic [3:0]     cnt, cnt_n;
    logic [7:0]     cmd_sr, cmd_sr_n;
    logic [23:0]    addr, addr_n;
    logic [7:0]     mode, mode_n;
    logic           xip_n;
    logic [AW-1:0]  ptr, ptr_n;
    logic           half, half_n;
    logic [3:0]     io_out_n;
    logic           io_oe_n;
    logic [7:0]     rd_byte;

    logic [7:0] mem [DEPTH];

    // Only the low AW address bits and the low mode nibble feed later logic.
    logic unused_bits;
    assign unused_bits = ^{addr[23:20], mode[7:4], cmd_sr[7]};

    assign rise = sck & ~sck_d & ~ce_n;
    assign fall = ~sck & sck_d & ~ce_n;

    // Combinational read: a same-cycle preload write lands after this sample.
    assign rd_byte = mem[ptr];

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sck_d  <= 1'b0;
            cnt    <= '0;
            cmd_sr <= '0;
            addr   <= '0;
            mode   <= '0;
            xip    <= 1'b0;
            ptr    <= '0;
            half   <= 1'b0;
            io_out <= '0;
            io_oe  <= 1'b0;
        end else begin
            state  <= state_n;
            sck_d  <= sck;
            cnt    <= cnt_n;
            cmd_sr <= cmd_sr_n;
            addr   <= addr_n;
            mode   <= mode_n;
            xip    <= xip_n;
            ptr    <= ptr_n;
            half   <= half_n;
            io_out <= io_out_n;
            io_oe  <= io_oe_n;
        end
    end

    always_comb begin
        // A select arriving in IDLE is handled as the first cycle of the
        // transaction so a rise in that same cycle is not lost.
        cur = state;
        if (state == IDLE && !ce_n)
            cur = xip ? ADDR : CMD;

        state_n  = cur;
        cnt_n    = cnt;
        cmd_sr_n = cmd_sr;
        addr_n   = addr;
        mode_n   = mode;
        xip_n    = xip;
        ptr_n    = ptr;
        half_n   = half;
        io_out_n = io_out;
        io_oe_n  = io_oe;

        if (ce_n) begin
            state_n = IDLE;
            cnt_n   = '0;
            half_n  = 1'b0;
            io_oe_n = 1'b0;
        end else begin
            case (cur)
                CMD: if (rise) begin
                    cmd_sr_n = {cmd_sr[6:0], io_in[0]};
                    cnt_n    = cnt + 4'd1;
                    if (cnt == CMD_LAST) begin
                        cnt_n   = '0;
                        state_n = (cmd_sr_n == CMD_QIOR) ? ADDR : IGNORE;
                    end
                end
                ADDR: if (rise) begin
                    addr_n = {addr[19:0], io_in};
                    cnt_n  = cnt + 4'd1;
                    if (cnt == ADDR_LAST) begin
                        cnt_n   = '0;
                        state_n = MODE;
                    end
                end
                MODE: if (rise) begin
                    mode_n = {mode[3:0], io_in};
                    cnt_n  = cnt + 4'd1;
                    if (cnt == MODE_LAST) begin
                        cnt_n   = '0;
                        xip_n   = (mode_n[5:4] == 2'b10);
                        state_n = DUMMY;
                    end
                end
                DUMMY: if (rise) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == DUMMY_LAST) begin
                        cnt_n   = '0;
                        ptr_n   = addr[AW-1:0];
                        half_n  = 1'b0;
                        state_n = DATA;
                    end
                end
                DATA: if (fall) begin
                    io_out_n = half ? rd_byte[3:0] : rd_byte[7:4];
                    io_oe_n  = 1'b1;
                    half_n   = ~half;
                    if (half)
                        ptr_n = ptr + AW'(1);
                end
                IGNORE: io_oe_n = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
